// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------
// Multi-cycle sequencer for an RV32I datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It drives the PC, IR,
// register-file and memory enables, and the PC and writeback mux selects.
// One shared, variable-latency memory port serves both instruction fetch
// and data access.
//
// Handshake: mem_req is held high in FETCH and MEM. The access completes
// in the first cycle where mem_req and mem_ready are both high. mem_ready
// is ignored in every other state.
//
// Ports
//   clk            in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   opcode         in   7  instr[6:0] from IR, stable from DECODE until FETCH
//   branch_taken   in   1  datapath branch decision, used in EXEC only
//   mem_ready      in   1  shared memory completes the access this cycle
//   mem_req        out  1  memory access request (fetch or data)
//   mem_we         out  1  store strobe (MEM state of a STORE)
//   ir_write       out  1  load IR from memory read data
//   reg_write      out  1  register-file write enable
//   wb_sel         out  2  00 ALU, 01 mem data, 10 pc+4
//   pc_write       out  1  PC update enable
//   pc_sel         out  2  00 pc+4, 01 branch target, 10 jump target
//   instr_retired  out  1  one-cycle pulse when an instruction completes
//   illegal        out  1  sticky: unsupported opcode decoded
//   mem_err        out  1  sticky: memory wait exceeded STALL_LIMIT
//   state          out  3  current state encoding (debug)

module multicycle_ctrl #(
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       instr_retired,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The counter value during the Nth consecutive wait cycle is N-1. The
    // error fires in the wait cycle that would bring the count to STALL_LIMIT.
    localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

    state_t     r_state;
    logic [7:0] r_stall_cnt;
    logic       r_illegal;
    logic       r_mem_err;

    state_t     w_state_next;
    logic       w_set_illegal;
    logic       w_set_mem_err;
    logic       w_stall_expired;
    logic       w_is_legal;
    logic       w_is_store;
    logic       w_is_jump;
    logic       w_mem_state;

    assign w_is_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                        (opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                        (opcode == OP_JAL) || (opcode == OP_JALR);
    assign w_is_store      = (opcode == OP_STORE);
    assign w_is_jump       = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign w_stall_expired = (r_stall_cnt >= STALL_LAST);
    assign w_mem_state     = (r_state == S_FETCH) || (r_state == S_MEM);

    assign state   = r_state;
    assign illegal = r_illegal;
    assign mem_err = r_mem_err;

    // State register, sticky flags and the memory stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_stall_cnt <= 8'd0;
            r_illegal   <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_mem_err) r_mem_err <= 1'b1;
            if (w_state_next != r_state)
                r_stall_cnt <= 8'd0;
            else if (w_mem_state && !mem_ready)
                r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    // Next-state and control-output decode.
    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        w_set_mem_err = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        pc_write      = 1'b0;
        pc_sel        = 2'b00;
        instr_retired = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_stall_expired) begin
                    w_set_mem_err = 1'b1;
                    w_state_next  = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_is_legal) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_next  = S_HALT;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE:              w_state_next = S_MEM;
                    OP_R, OP_I, OP_JAL, OP_JALR:    w_state_next = S_WB;
                    OP_BRANCH: begin
                        pc_write      = 1'b1;
                        pc_sel        = branch_taken ? 2'b01 : 2'b00;
                        instr_retired = 1'b1;
                        w_state_next  = S_FETCH;
                    end
                    // Opcode changed under us after DECODE: park safely.
                    default:                        w_state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        w_state_next  = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_stall_expired) begin
                    w_set_mem_err = 1'b1;
                    w_state_next  = S_HALT;
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                w_state_next  = S_FETCH;
                if (opcode == OP_LOAD) wb_sel = 2'b01;
                else if (w_is_jump)    wb_sel = 2'b10;
                if (w_is_jump)         pc_sel = 2'b10;
            end
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_HALT;
        endcase

        // Reset discards the in-flight instruction: no enables this cycle.
        if (reset) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = 2'b00;
            pc_write      = 1'b0;
            pc_sel        = 2'b00;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each cycle the bench drives the
// inputs, lets the combinational outputs settle, and compares the full
// output vector against a hand-written expectation.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_write, reg_write, pc_write;
    logic       instr_retired, illegal, mem_err;
    logic [1:0] wb_sel, pc_sel;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Clock / reset block.
    always #5 clk = ~clk;

    multicycle_ctrl #(.STALL_LIMIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .instr_retired (instr_retired),
        .illegal       (illegal),
        .mem_err       (mem_err),
        .state         (state)
    );

    // Observed vector: {mem_req, mem_we, ir_write, reg_write, wb_sel,
    //                   pc_write, pc_sel, instr_retired, illegal, mem_err, state}
    logic [14:0] obs;
    assign obs = {mem_req, mem_we, ir_write, reg_write, wb_sel,
                  pc_write, pc_sel, instr_retired, illegal, mem_err, state};

    function automatic logic [14:0] ev(input logic mreq, input logic mwe, input logic irw,
                                       input logic rw, input logic [1:0] wbs, input logic pcw,
                                       input logic [1:0] pcs, input logic ret, input logic ill,
                                       input logic err, input logic [2:0] st);
        return {mreq, mwe, irw, rw, wbs, pcw, pcs, ret, ill, err, st};
    endfunction

    // Driver task: apply inputs for one cycle, check settled outputs, advance.
    // Called #1 after a rising edge so sampling is away from the edge.
    task automatic cyc(input string tag, input logic rst, input logic [6:0] opc,
                       input logic mr, input logic bt, input logic [14:0] exp_v);
        reset        = rst;
        opcode       = opc;
        mem_ready    = mr;
        branch_taken = bt;
        #2;
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one reset cycle without checking the (flag) outputs.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    localparam logic [14:0] IDLE_FETCH = 15'b1_0_0_0_00_0_00_0_0_0_000;

    initial begin
        reset = 1'b1; opcode = OP_R; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;

        // Reset state: state 0, everything gated low while reset is high.
        cyc("reset_hold", 1, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd0));

        // 1. R-type, zero-wait memory: 0,1,2,4 then back to 0.
        cyc("r_fetch",  0, OP_R, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("r_decode", 0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("r_exec",   0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("r_wb",     0, OP_R, 1, 0, ev(0,0,0,1,2'b00,1,2'b00,1,0,0,3'd4));

        // I-ALU behaves like R-type.
        cyc("i_fetch",  0, OP_I, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("i_decode", 0, OP_I, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("i_exec",   0, OP_I, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("i_wb",     0, OP_I, 1, 0, ev(0,0,0,1,2'b00,1,2'b00,1,0,0,3'd4));

        // 2. LOAD with two wait cycles in MEM: 7 cycles total, mem_we stays 0.
        cyc("ld_fetch",  0, OP_LOAD, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("ld_decode", 0, OP_LOAD, 0, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("ld_exec",   0, OP_LOAD, 0, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("ld_mem_w1", 0, OP_LOAD, 0, 0, ev(1,0,0,0,2'b00,0,2'b00,0,0,0,3'd3));
        cyc("ld_mem_w2", 0, OP_LOAD, 0, 0, ev(1,0,0,0,2'b00,0,2'b00,0,0,0,3'd3));
        cyc("ld_mem_ok", 0, OP_LOAD, 1, 0, ev(1,0,0,0,2'b00,0,2'b00,0,0,0,3'd3));
        cyc("ld_wb",     0, OP_LOAD, 1, 0, ev(0,0,0,1,2'b01,1,2'b00,1,0,0,3'd4));

        // 3. BRANCH taken, then not taken (branch_taken ignored outside EXEC).
        cyc("bt_fetch",  0, OP_BRANCH, 1, 1, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("bt_decode", 0, OP_BRANCH, 1, 1, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("bt_exec",   0, OP_BRANCH, 1, 1, ev(0,0,0,0,2'b00,1,2'b01,1,0,0,3'd2));
        cyc("bn_fetch",  0, OP_BRANCH, 1, 1, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("bn_decode", 0, OP_BRANCH, 1, 1, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("bn_exec",   0, OP_BRANCH, 1, 0, ev(0,0,0,0,2'b00,1,2'b00,1,0,0,3'd2));

        // 4. JAL and JALR writeback selects.
        cyc("jal_fetch",  0, OP_JAL, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("jal_decode", 0, OP_JAL, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("jal_exec",   0, OP_JAL, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("jal_wb",     0, OP_JAL, 1, 0, ev(0,0,0,1,2'b10,1,2'b10,1,0,0,3'd4));
        cyc("jalr_fetch", 0, OP_JALR, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("jalr_dec",   0, OP_JALR, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("jalr_exec",  0, OP_JALR, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("jalr_wb",    0, OP_JALR, 1, 0, ev(0,0,0,1,2'b10,1,2'b10,1,0,0,3'd4));

        // STORE, zero wait: retires out of MEM with mem_we.
        cyc("st_fetch",  0, OP_STORE, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("st_decode", 0, OP_STORE, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("st_exec",   0, OP_STORE, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("st_mem",    0, OP_STORE, 1, 0, ev(1,1,0,0,2'b00,1,2'b00,1,0,0,3'd3));

        // 6b. FETCH stall, mem_ready arrives on the 15th cycle: no error.
        for (int i = 0; i < 14; i++)
            cyc("stall_ok_wait", 0, OP_R, 0, 0, IDLE_FETCH);
        cyc("stall_ok_last", 0, OP_R, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("stall_ok_dec",  0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("stall_ok_exec", 0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("stall_ok_wb",   0, OP_R, 1, 0, ev(0,0,0,1,2'b00,1,2'b00,1,0,0,3'd4));

        // 6c. Reset asserted in MEM of a STORE: gated outputs, then clean FETCH.
        cyc("rs_fetch",  0, OP_STORE, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("rs_decode", 0, OP_STORE, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("rs_exec",   0, OP_STORE, 0, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("rs_mem_rst", 1, OP_STORE, 0, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd3));
        cyc("rs_after",  0, OP_STORE, 0, 0, IDLE_FETCH);
        cyc("rs_fetch2", 0, OP_R, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("rs_dec2",   0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        cyc("rs_exec2",  0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        cyc("rs_wb2",    0, OP_R, 1, 0, ev(0,0,0,1,2'b00,1,2'b00,1,0,0,3'd4));

        // 5. Illegal opcode: HALT with illegal set, enables held low.
        cyc("ill_fetch",  0, OP_BAD, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));
        cyc("ill_decode", 0, OP_BAD, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        for (int i = 0; i < 20; i++)
            cyc("ill_halt", 0, OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ev(0,0,0,0,2'b00,0,2'b00,0,1,0,3'd5));
        do_reset();
        cyc("ill_cleared", 0, OP_R, 0, 0, IDLE_FETCH);

        // 6a. FETCH stall with mem_ready held low: error after 15 wait cycles.
        // The FETCH cycle just checked above was wait cycle 1.
        for (int i = 0; i < 14; i++)
            cyc("stall_wait", 0, OP_R, 0, 0, IDLE_FETCH);
        cyc("stall_halt1", 0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,1,3'd5));
        cyc("stall_halt2", 0, OP_R, 1, 0, ev(0,0,0,0,2'b00,0,2'b00,0,0,1,3'd5));
        do_reset();
        cyc("err_cleared", 0, OP_R, 1, 0, ev(1,0,1,0,2'b00,0,2'b00,0,0,0,3'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
